// File: rtl/md_pkg.sv
// Shared op codes, FSM state type and op-class helpers for the multiply/divide unit.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit for a multi-cycle run and raise busy.
    function automatic logic is_md_busy_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_md_mult_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the full {hi,lo} result,
// including signed overflow and divide-by-zero conventions.
module md_arith
    import md_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo
);

    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] sa_ext, sb_ext, s_prod;
    logic        [2*DATA_W-1:0] ua_ext, ub_ext, u_prod;
    logic signed [DATA_W-1:0]   sa, sb, s_quo, s_rem;
    logic        [DATA_W-1:0]   u_quo, u_rem;

    always_comb begin
        sa     = a;
        sb     = b;
        sa_ext = {{DATA_W{a[DATA_W-1]}}, a};
        sb_ext = {{DATA_W{b[DATA_W-1]}}, b};
        ua_ext = {{DATA_W{1'b0}}, a};
        ub_ext = {{DATA_W{1'b0}}, b};
        s_prod = sa_ext * sb_ext;
        u_prod = ua_ext * ub_ext;
        s_quo  = '0;
        s_rem  = '0;
        u_quo  = '0;
        u_rem  = '0;
        // Dividers only see a nonzero divisor; the zero case is selected below.
        if (b != '0) begin
            s_quo = sa / sb;
            s_rem = sa % sb;
            u_quo = a / b;
            u_rem = a % b;
        end

        res_hi = '0;
        res_lo = '0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = s_prod;
            MD_MULTU: {res_hi, res_lo} = u_prod;
            MD_DIV: begin
                if (b == '0) begin
                    res_lo = '1;
                    res_hi = a;
                end else if ((a == MIN_VAL) && (b == '1)) begin
                    res_lo = MIN_VAL;
                    res_hi = '0;
                end else begin
                    res_lo = s_quo;
                    res_hi = s_rem;
                end
            end
            MD_DIVU: begin
                if (b == '0) begin
                    res_lo = '1;
                    res_hi = a;
                end else begin
                    res_lo = u_quo;
                    res_hi = u_rem;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers; the result is
// computed at issue and held in pending registers until the latency counter expires.
module md_unit
    import md_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              md_start,
    input  logic [2:0]        md_op,
    input  logic [DATA_W-1:0] md_a,
    input  logic [DATA_W-1:0] md_b,
    output logic              busy,
    output logic              md_hazard,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e         state;
    logic [CNT_W-1:0]  counter;
    logic [DATA_W-1:0] pending_hi, pending_lo;
    logic [DATA_W-1:0] res_hi, res_lo;

    md_arith #(.DATA_W(DATA_W)) u_arith (
        .op     (md_op),
        .a      (md_a),
        .b      (md_b),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_comb md_hazard = busy | (md_start & is_md_busy_op(md_op));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (md_start) begin
                        if (is_md_busy_op(md_op)) begin
                            pending_hi <= res_hi;
                            pending_lo <= res_lo;
                            counter    <= is_md_mult_op(md_op) ? CNT_W'(MULT_CYCLES)
                                                               : CNT_W'(DIV_CYCLES);
                            busy       <= 1'b1;
                            state      <= RUN;
                        end else if (md_op == MD_MTHI) begin
                            hi <= md_a;
                        end else if (md_op == MD_MTLO) begin
                            lo <= md_a;
                        end
                    end
                end
                RUN: begin
                    // md_start is deliberately ignored here; the hazard logic prevents it.
                    counter <= counter - 1'b1;
                    if (counter == CNT_W'(1)) begin
                        hi    <= pending_hi;
                        lo    <= pending_lo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table with a done-driven scoreboard,
// plus hand sequences for MTHI/MTLO, issue-while-busy and mid-run reset.
module tb_md_unit;
    import md_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, md_start;
    logic [2:0]  md_op;
    logic [31:0] md_a, md_b;
    logic        busy, md_hazard, done;
    logic [31:0] hi, lo;

    md_unit #(.DATA_W(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_a      (md_a),
        .md_b      (md_b),
        .busy      (busy),
        .md_hazard (md_hazard),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    typedef struct packed {
        logic [31:0] h;
        logic [31:0] l;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          illegal_issues = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done) begin
            chk("done_has_pending", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_hi", 64'(hi), 64'(e.h));
                chk("sb_lo", 64'(lo), 64'(e.l));
                cur_hi = e.h;
                cur_lo = e.l;
            end
        end
    end

    // Issue while busy is illegal for the pipeline; count each occurrence.
    always @(posedge clk) begin
        if (!reset && md_start && busy) illegal_issues++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        md_start = 1'b0;
        md_op    = MD_NONE;
        md_a     = '0;
        md_b     = '0;
    endtask

    // Issue one busy op at a negedge and track it through its whole run.
    task automatic run_vec(input vec_t v);
        int n;
        n = is_md_mult_op(v.op) ? MC : DC;
        @(negedge clk);
        md_start = 1'b1; md_op = v.op; md_a = v.a; md_b = v.b;
        #1;
        chk("hazard_on_issue", 64'(md_hazard), 64'd1);
        sb_q.push_back({v.exp_hi, v.exp_lo});
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            idle_inputs();
            if (k == 1 || k == n) begin
                chk("busy_in_run", 64'(busy), 64'd1);
                chk("no_done_in_run", 64'(done), 64'd0);
                chk("hi_held", 64'(hi), 64'(cur_hi));
                chk("lo_held", 64'(lo), 64'(cur_lo));
            end
        end
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_cleared", 64'(busy), 64'd0);
        @(negedge clk);
        chk("done_single", 64'(done), 64'd0);
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{MD_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[5]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[6]  = '{MD_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[7]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[9]  = '{MD_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        vecs[10] = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // MTHI then MTLO on consecutive cycles.
        @(negedge clk);
        md_start = 1'b1; md_op = MD_MTHI; md_a = 32'hAAAA0000;
        #1 chk("mthi_no_hazard", 64'(md_hazard), 64'd0);
        @(negedge clk);
        chk("mthi_hi", 64'(hi), 64'hAAAA0000);
        chk("mthi_lo_kept", 64'(lo), 64'(cur_lo));
        chk("mthi_busy", 64'(busy), 64'd0);
        md_op = MD_MTLO; md_a = 32'h00005555;
        @(negedge clk);
        idle_inputs();
        chk("mtlo_lo", 64'(lo), 64'h00005555);
        chk("mtlo_hi_kept", 64'(hi), 64'hAAAA0000);
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_done", 64'(done), 64'd0);
        cur_hi = 32'hAAAA0000;
        cur_lo = 32'h00005555;

        // NONE and an undefined code change nothing.
        @(negedge clk);
        md_start = 1'b1; md_op = MD_NONE; md_a = 32'h1111;
        @(negedge clk);
        md_op = 3'd7;
        @(negedge clk);
        idle_inputs();
        chk("none_hi", 64'(hi), 64'hAAAA0000);
        chk("none_lo", 64'(lo), 64'h00005555);
        chk("none_busy", 64'(busy), 64'd0);

        // MTLO issued in the middle of a MULT run is ignored.
        @(negedge clk);
        md_start = 1'b1; md_op = MD_MULT; md_a = 32'd3; md_b = 32'd4;
        sb_q.push_back({32'h0, 32'hC});
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        md_start = 1'b1; md_op = MD_MTLO; md_a = 32'hDEADBEEF;
        @(negedge clk);
        idle_inputs();
        chk("busy_mtlo_ignored", 64'(lo), 64'h00005555);
        repeat (4) @(negedge clk);
        chk("busy_mtlo_final_lo", 64'(lo), 64'h0000000C);
        chk("illegal_issue_seen", 64'(illegal_issues), 64'd1);

        // Reset during RUN cycle 3 of a DIV discards the result.
        @(negedge clk);
        md_start = 1'b1; md_op = MD_DIV; md_a = 32'd100; md_b = 32'd3;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_hi", 64'(hi), 64'd0);
        chk("mid_rst_lo", 64'(lo), 64'd0);
        cur_hi = '0;
        cur_lo = '0;
        for (int k = 0; k < DC + 4; k++) begin
            @(negedge clk);
            if (done) chk("no_done_after_reset", 64'(done), 64'd0);
        end
        chk("final_done_low", 64'(done), 64'd0);
        chk("final_hi", 64'(hi), 64'd0);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
